// File: rtl/int_issue_arbiter_pkg.sv
// Unit codes, fixed integer latency and sizing helper shared by the issue arbiter slice.
package issue_arb_pkg;

  typedef enum logic [1:0] {
    UNIT_INT  = 2'd0,
    UNIT_MUL  = 2'd1,
    UNIT_DIV  = 2'd2,
    UNIT_NONE = 2'd3
  } unit_e;

  localparam int INT_LAT = 1;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/int_issue_arbiter_cdb_slot_tracker.sv
// CDB write-back booking shift register: res/src slot k describes the cycle k cycles from now.
module cdb_slot_tracker
  import issue_arb_pkg::*;
#(
  parameter int MAXL = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            book,
  input  logic [3:0]      book_lat,
  input  logic [1:0]      book_src,
  output logic [MAXL:0]   busy,
  output logic            cdb_drive_valid,
  output logic [1:0]      cdb_drive_sel
);

  logic [MAXL:0] res_q, res_d;
  logic [1:0]    src_q [0:MAXL];
  logic [1:0]    src_d [0:MAXL];

  always_comb begin
    res_d = '0;
    for (int k = 0; k <= MAXL; k++) src_d[k] = UNIT_NONE;
    // A booking of latency L lands in slot L-1 because every slot also moves one step closer.
    for (int k = 0; k < MAXL; k++) begin
      if (book && (int'(book_lat) == k + 1)) begin
        res_d[k] = 1'b1;
        src_d[k] = book_src;
      end else begin
        res_d[k] = res_q[k+1];
        src_d[k] = src_q[k+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      for (int k = 0; k <= MAXL; k++) src_q[k] <= UNIT_NONE;
    end else begin
      res_q <= res_d;
      for (int k = 0; k <= MAXL; k++) src_q[k] <= src_d[k];
    end
  end

  assign busy            = res_q;
  assign cdb_drive_valid = res_q[0];
  assign cdb_drive_sel   = src_q[0];

endmodule

// File: rtl/int_issue_arbiter.sv
// Round-robin issue arbiter for int/mul/div stations with CDB slot booking.
// Optional stall counter enabled by defining ARB_PERF_CNT_EN.
module int_issue_arbiter
  import issue_arb_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_issueque_ready,
  input  logic        mul_issueque_ready,
  input  logic        div_issueque_ready,
  output logic        int_issueblk_done,
  output logic        mul_issueblk_done,
  output logic        div_issueblk_done,
  output logic        issue_valid,
  output logic [1:0]  issue_unit,
  output logic        cdb_drive_valid,
  output logic [1:0]  cdb_drive_sel,
  output logic        div_busy,
  output logic [15:0] arb_stall_count
);

  localparam int MAXL = max(MUL_LAT, DIV_LAT);

  logic [MAXL:0] busy;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]    div_cnt_q, div_cnt_d;
  logic [2:0]    elig;
  logic          gnt_vld;
  unit_e         gnt_unit;
  logic [3:0]    book_lat;
  logic          cdb_vld_raw;
  logic [1:0]    cdb_sel_raw;

  assign elig[0] = int_issueque_ready && !busy[INT_LAT];
  assign elig[1] = mul_issueque_ready && !busy[MUL_LAT];
  assign elig[2] = div_issueque_ready && !busy[DIV_LAT] && (div_cnt_q == 4'd0);

  always_comb begin : rr_select
    int sum;
    logic [1:0] cand;
    sum      = 0;
    cand     = 2'd0;
    gnt_vld  = 1'b0;
    gnt_unit = UNIT_NONE;
    for (int i = 0; i < 3; i++) begin
      sum = int'(rr_ptr_q) + i;
      if (sum >= 3) sum = sum - 3;
      cand = sum[1:0];
      if (!gnt_vld && elig[cand]) begin
        gnt_vld  = 1'b1;
        gnt_unit = unit_e'(cand);
      end
    end
    if (reset) begin
      gnt_vld  = 1'b0;
      gnt_unit = UNIT_NONE;
    end
  end

  always_comb begin
    case (gnt_unit)
      UNIT_MUL: book_lat = 4'(MUL_LAT);
      UNIT_DIV: book_lat = 4'(DIV_LAT);
      default:  book_lat = 4'(INT_LAT);
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      case (gnt_unit)
        UNIT_INT: rr_ptr_d = 2'd1;
        UNIT_MUL: rr_ptr_d = 2'd2;
        default:  rr_ptr_d = 2'd0;
      endcase
    end
    div_cnt_d = div_cnt_q;
    if (gnt_vld && gnt_unit == UNIT_DIV) div_cnt_d = 4'(DIV_LAT - 1);
    else if (div_cnt_q != 4'd0)          div_cnt_d = div_cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= 2'd0;
      div_cnt_q <= 4'd0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  cdb_slot_tracker #(.MAXL(MAXL)) u_slots (
    .clk             (clk),
    .reset           (reset),
    .book            (gnt_vld),
    .book_lat        (book_lat),
    .book_src        (gnt_unit),
    .busy            (busy),
    .cdb_drive_valid (cdb_vld_raw),
    .cdb_drive_sel   (cdb_sel_raw)
  );

  assign int_issueblk_done = gnt_vld && (gnt_unit == UNIT_INT);
  assign mul_issueblk_done = gnt_vld && (gnt_unit == UNIT_MUL);
  assign div_issueblk_done = gnt_vld && (gnt_unit == UNIT_DIV);
  assign issue_valid       = gnt_vld;
  assign issue_unit        = gnt_unit;
  // Registered views are masked so the reset cycle itself shows idle values.
  assign cdb_drive_valid   = !reset && cdb_vld_raw;
  assign cdb_drive_sel     = reset ? UNIT_NONE : cdb_sel_raw;
  assign div_busy          = !reset && (div_cnt_q != 4'd0);

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        any_ready;

  assign any_ready = int_issueque_ready || mul_issueque_ready || div_issueque_ready;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (any_ready && !gnt_vld && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign arb_stall_count = reset ? 16'd0 : stall_cnt_q;
`else
  assign arb_stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_int_issue_arbiter.sv
// Self-checking bench for int_issue_arbiter against an absolute-time CDB booking model.
module tb_int_issue_arbiter;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_issueque_ready, mul_issueque_ready, div_issueque_ready;
  logic        int_issueblk_done, mul_issueblk_done, div_issueblk_done;
  logic        issue_valid;
  logic [1:0]  issue_unit;
  logic        cdb_drive_valid;
  logic [1:0]  cdb_drive_sel;
  logic        div_busy;
  logic [15:0] arb_stall_count;

  int total = 0;
  int bad   = 0;

  // Model state: absolute cycle numbers of CDB ownership, last div grant, rr start, stalls.
  int owner [int];
  int cyc;
  int last_div;
  int rr;
  int stall;

  int_issue_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk                (clk),
    .reset              (reset),
    .int_issueque_ready (int_issueque_ready),
    .mul_issueque_ready (mul_issueque_ready),
    .div_issueque_ready (div_issueque_ready),
    .int_issueblk_done  (int_issueblk_done),
    .mul_issueblk_done  (mul_issueblk_done),
    .div_issueblk_done  (div_issueblk_done),
    .issue_valid        (issue_valid),
    .issue_unit         (issue_unit),
    .cdb_drive_valid    (cdb_drive_valid),
    .cdb_drive_sel      (cdb_drive_sel),
    .div_busy           (div_busy),
    .arb_stall_count    (arb_stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    owner.delete();
    last_div = -1000;
    rr       = 0;
    stall    = 0;
    cyc      = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    int_issueque_ready = 1'b1;
    mul_issueque_ready = 1'b1;
    div_issueque_ready = 1'b1;
    @(negedge clk);
    check("rst_done", 16'({div_issueblk_done, mul_issueblk_done, int_issueblk_done}), 16'd0);
    check("rst_issue_valid", 16'(issue_valid), 16'd0);
    check("rst_issue_unit", 16'(issue_unit), 16'd3);
    check("rst_cdb_valid", 16'(cdb_drive_valid), 16'd0);
    check("rst_cdb_sel", 16'(cdb_drive_sel), 16'd3);
    check("rst_div_busy", 16'(div_busy), 16'd0);
    check("rst_stall_cnt", arb_stall_count, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    int_issueque_ready = 1'b0;
    mul_issueque_ready = 1'b0;
    div_issueque_ready = 1'b0;
    model_clear();
  endtask

  // One cycle: drive readies, compare all outputs to the model, then advance the model.
  task automatic step(input logic ri, input logic rm, input logic rd, input int exp_u);
    int lat [3];
    bit el  [3];
    int g;
    int u;
    int since;
    lat = '{1, MUL_LAT, DIV_LAT};
    int_issueque_ready = ri;
    mul_issueque_ready = rm;
    div_issueque_ready = rd;
    @(negedge clk);
    since = cyc - last_div;
    el[0] = ri && !owner.exists(cyc + 1);
    el[1] = rm && !owner.exists(cyc + MUL_LAT);
    el[2] = rd && !owner.exists(cyc + DIV_LAT) && (since >= DIV_LAT);
    g = 3;
    for (int i = 0; i < 3; i++) begin
      u = (rr + i) % 3;
      if (g == 3 && el[u]) g = u;
    end
    if (exp_u >= 0) check("directed_unit", 16'(issue_unit), 16'(exp_u));
    check("issue_unit", 16'(issue_unit), 16'(g));
    check("issue_valid", 16'(issue_valid), 16'(g != 3));
    check("done_pulses", 16'({div_issueblk_done, mul_issueblk_done, int_issueblk_done}),
          (g == 3) ? 16'd0 : 16'(1 << g));
    check("cdb_valid", 16'(cdb_drive_valid), 16'(owner.exists(cyc)));
    check("cdb_sel", 16'(cdb_drive_sel), owner.exists(cyc) ? 16'(owner[cyc]) : 16'd3);
    check("div_busy", 16'(div_busy), 16'(since > 0 && since < DIV_LAT));
`ifdef ARB_PERF_CNT_EN
    check("stall_cnt", arb_stall_count, 16'(stall));
`else
    check("stall_cnt", arb_stall_count, 16'd0);
`endif
    if (g != 3) begin
      owner[cyc + lat[g]] = g;
      rr = (g + 1) % 3;
      if (g == 2) last_div = cyc;
    end else if ((ri || rm || rd) && stall < 65535) begin
      stall++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    int_issueque_ready = 1'b0;
    mul_issueque_ready = 1'b0;
    div_issueque_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    // Idle after reset.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 3);

    // Integer back-to-back, CDB one cycle later.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 3);

    // All ready: round-robin order, div skipped while busy.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 1'b1, 2);
    step(1'b1, 1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, -1);

    // Slot conflict: mul books slot 4, int refused at 3, granted at 4.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 3);

    // Two blocked int cycles feed the stall counter.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 0);
`ifdef ARB_PERF_CNT_EN
    check("stall_two", arb_stall_count, 16'd2);
`else
    check("stall_two", arb_stall_count, 16'd0);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 3);

    // Div then mid-operation reset: booking discarded, new div immediate.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 1'b0, 3);
    do_reset();
    step(1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; i < DIV_LAT + 3; i++) step(1'b0, 1'b0, 1'b0, -1);

    // Randomized readies against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    for (int i = 0; i < DIV_LAT + 2; i++) step(1'b0, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
